// File: rtl/l2_cache_pkg.sv
// Shared types and geometry helpers for the L2 cache controller.
// Pure declarations; no timing or flow-control behaviour of its own.
package l2_cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    function automatic int offset_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int index_w(input int cache_size, input int assoc, input int data_width);
        return $clog2(cache_size / ((data_width / 8) * assoc));
    endfunction

    function automatic int tag_w(input int addr_width, input int cache_size, input int assoc,
                                 input int data_width);
        return addr_width - index_w(cache_size, assoc, data_width) - offset_w(data_width);
    endfunction

endpackage

// File: rtl/l2_cache_controller_if.sv
// L1-side and memory-side request/ready pulse handshakes of the L2 controller.
// slave = the controller; master = the L1 + backing-memory environment.
interface l2_cache_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  l1_request;
    logic                  l1_write_enable;
    logic [ADDR_WIDTH-1:0] l1_address;
    logic [DATA_WIDTH-1:0] l1_write_data;
    logic [DATA_WIDTH-1:0] l1_response_data;
    logic                  l1_ready;
    logic                  mem_request;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_response_data;
    logic                  mem_ready;

    modport slave (
        input  l1_request, l1_write_enable, l1_address, l1_write_data,
        input  mem_response_data, mem_ready,
        output l1_response_data, l1_ready,
        output mem_request, mem_write_enable, mem_address, mem_write_data
    );

    modport master (
        output l1_request, l1_write_enable, l1_address, l1_write_data,
        output mem_response_data, mem_ready,
        input  l1_response_data, l1_ready,
        input  mem_request, mem_write_enable, mem_address, mem_write_data
    );
endinterface

// File: rtl/l2_cache_controller_lru_tracker.sv
// True-LRU age tracker: per-set permutation of ages, age 0 = most recently used.
// Touch takes effect on the next edge; victim query is combinational.
module lru_tracker #(
    parameter int ASSOCIATIVITY = 4,
    parameter int NUM_SETS      = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             touch_en,
    input  logic [$clog2(NUM_SETS)-1:0]      touch_set,
    input  logic [$clog2(ASSOCIATIVITY)-1:0] touch_way,
    input  logic [$clog2(NUM_SETS)-1:0]      query_set,
    output logic [$clog2(ASSOCIATIVITY)-1:0] victim_way
);
    localparam int WAY_W = $clog2(ASSOCIATIVITY);

    function automatic logic [ASSOCIATIVITY-1:0][WAY_W-1:0] age_init();
        logic [ASSOCIATIVITY-1:0][WAY_W-1:0] r;
        for (int w = 0; w < ASSOCIATIVITY; w++) r[w] = WAY_W'(w);
        return r;
    endfunction

    localparam logic [ASSOCIATIVITY-1:0][WAY_W-1:0] AGE_INIT = age_init();

    logic [NUM_SETS-1:0][ASSOCIATIVITY-1:0][WAY_W-1:0] age;
    logic [ASSOCIATIVITY-1:0][WAY_W-1:0]               touched_row;

    // Ways younger than the touched one age by one; the touched way becomes youngest.
    always_comb begin
        touched_row = age[touch_set];
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (WAY_W'(w) == touch_way)
                touched_row[w] = '0;
            else if (age[touch_set][w] < age[touch_set][touch_way])
                touched_row[w] = age[touch_set][w] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            age <= {NUM_SETS{AGE_INIT}};
        else if (touch_en)
            age[touch_set] <= touched_row;
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (age[query_set][w] == WAY_W'(ASSOCIATIVITY - 1))
                victim_way = WAY_W'(w);
        end
    end

endmodule

// File: rtl/l2_cache_controller.sv
// Set-associative write-back/write-allocate L2 controller, one word per line, true LRU.
// Hit answers 2 cycles after sampling; misses stall on memory handshakes, one transaction at a time.
module l2_cache_controller
    import l2_cache_pkg::*;
#(
    parameter int CACHE_SIZE    = 16384,
    parameter int ASSOCIATIVITY = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    l2_cache_controller_if.slave bus,
    output logic [2:0]           c_state,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int NUM_SETS = CACHE_SIZE / ((DATA_WIDTH / 8) * ASSOCIATIVITY);
    localparam int OFFSET_W = offset_w(DATA_WIDTH);
    localparam int INDEX_W  = index_w(CACHE_SIZE, ASSOCIATIVITY, DATA_WIDTH);
    localparam int TAG_W    = tag_w(ADDR_WIDTH, CACHE_SIZE, ASSOCIATIVITY, DATA_WIDTH);
    localparam int WAY_W    = $clog2(ASSOCIATIVITY);

    state_t                  state, state_nxt;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_W-1:0]      req_idx;
    logic                    req_we;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH-1:0]   resp_dat;
    logic [WAY_W-1:0]        victim_way, hit_way, inv_way, lru_way, touch_way;
    logic                    hit, has_inv, touch_en;

    logic [NUM_SETS-1:0][ASSOCIATIVITY-1:0] line_valid;
    logic [NUM_SETS-1:0][ASSOCIATIVITY-1:0] line_dirty;
    logic [TAG_W-1:0]      tag_mem  [NUM_SETS][ASSOCIATIVITY];
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][ASSOCIATIVITY];

    lru_tracker #(.ASSOCIATIVITY(ASSOCIATIVITY), .NUM_SETS(NUM_SETS)) u_lru (
        .clk        (clk),
        .reset      (reset),
        .touch_en   (touch_en),
        .touch_set  (req_idx),
        .touch_way  (touch_way),
        .query_set  (req_idx),
        .victim_way (lru_way)
    );

    // Descending scan so the lowest-index match/invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (line_valid[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!line_valid[req_idx][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        touch_en  = 1'b0;
        touch_way = hit_way;
        case (state)
            IDLE:      if (bus.l1_request && !bus.l1_ready) state_nxt = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    touch_en  = 1'b1;
                    state_nxt = RESPOND;
                end else if (!has_inv && line_dirty[req_idx][lru_way]) begin
                    state_nxt = WRITEBACK;
                end else begin
                    state_nxt = FILL;
                end
            end
            WRITEBACK: if (bus.mem_ready) state_nxt = FILL;
            FILL: begin
                if (bus.mem_ready) begin
                    touch_en  = 1'b1;
                    touch_way = victim_way;
                    state_nxt = RESPOND;
                end
            end
            RESPOND:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_tag    <= '0;
            req_idx    <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
            resp_dat   <= '0;
            victim_way <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            line_valid <= '0;
            line_dirty <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (state_nxt == LOOKUP) begin
                        req_tag   <= bus.l1_address[ADDR_WIDTH-1 -: TAG_W];
                        req_idx   <= bus.l1_address[OFFSET_W +: INDEX_W];
                        req_we    <= bus.l1_write_enable;
                        req_wdata <= bus.l1_write_data;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        hit_count <= hit_count + 32'd1;
                        if (req_we) line_dirty[req_idx][hit_way] <= 1'b1;
                        else        resp_dat <= data_mem[req_idx][hit_way];
                    end else begin
                        miss_count <= miss_count + 32'd1;
                        victim_way <= has_inv ? inv_way : lru_way;
                    end
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        line_valid[req_idx][victim_way] <= 1'b1;
                        line_dirty[req_idx][victim_way] <= req_we;
                        if (!req_we) resp_dat <= bus.mem_response_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity alone decides whether a line exists.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == LOOKUP && hit && req_we)
                data_mem[req_idx][hit_way] <= req_wdata;
            if (state == FILL && bus.mem_ready) begin
                tag_mem[req_idx][victim_way]  <= req_tag;
                data_mem[req_idx][victim_way] <= req_we ? req_wdata : bus.mem_response_data;
            end
        end
    end

    always_comb begin
        bus.mem_request      = (state == WRITEBACK) || (state == FILL);
        bus.mem_write_enable = (state == WRITEBACK);
        bus.mem_address      = '0;
        bus.mem_write_data   = '0;
        if (state == WRITEBACK) begin
            bus.mem_address    = {tag_mem[req_idx][victim_way], req_idx, {OFFSET_W{1'b0}}};
            bus.mem_write_data = data_mem[req_idx][victim_way];
        end else if (state == FILL) begin
            bus.mem_address = {req_tag, req_idx, {OFFSET_W{1'b0}}};
        end
    end

    assign bus.l1_ready         = (state == RESPOND);
    assign bus.l1_response_data = resp_dat;
    assign c_state              = state;

endmodule

// File: tb/tb_l2_cache_controller.sv
// Directed bench for l2_cache_controller with a 3-cycle-latency memory model.
// Scenario tasks run in sequence and compare against hand-computed values.
module tb_l2_cache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  c_state;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] fill_data = 32'h0;
    int          req_cycles = 0, txn_no = 0, wb_count = 0, fill_count = 0;
    int          wb_seq = 0, fill_seq = 0, mcnt = 0;
    logic [31:0] wb_addr = 32'h0, wb_data = 32'h0, fill_addr = 32'h0;

    always #5 clk = ~clk;

    l2_cache_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    l2_cache_controller #(
        .CACHE_SIZE(16384), .ASSOCIATIVITY(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .c_state    (c_state),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Memory model: raises mem_ready for one cycle in the third cycle of a request.
    initial begin
        bus.mem_ready         = 1'b0;
        bus.mem_response_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                bus.mem_ready = 1'b0;
                mcnt = 0;
            end else if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                mcnt = 0;
            end else if (bus.mem_request) begin
                req_cycles++;
                mcnt++;
                if (mcnt == 3) begin
                    bus.mem_ready = 1'b1;
                    txn_no++;
                    if (bus.mem_write_enable) begin
                        wb_count++;
                        wb_seq  = txn_no;
                        wb_addr = bus.mem_address;
                        wb_data = bus.mem_write_data;
                    end else begin
                        fill_count++;
                        fill_seq  = txn_no;
                        fill_addr = bus.mem_address;
                        bus.mem_response_data = fill_data;
                    end
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // One complete L1 transaction; lat counts cycles from the sampling edge to l1_ready.
    task automatic l1_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int lat);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        lat = 0;
        bus.l1_write_enable = we;
        bus.l1_address      = addr;
        bus.l1_write_data   = wdata;
        bus.l1_request      = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.l1_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL l1_timeout addr=%h got no l1_ready want l1_ready within 100 cycles", addr);
        end
        rdata = bus.l1_response_data;
        bus.l1_request = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (c_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", c_state); end
        checks++; if (bus.l1_ready !== 1'b0) begin errors++; $display("FAIL rst_l1_ready got %b want 0", bus.l1_ready); end
        checks++; if (bus.mem_request !== 1'b0) begin errors++; $display("FAIL rst_mem_request got %b want 0", bus.mem_request); end
        checks++; if (bus.mem_address !== 32'h0) begin errors++; $display("FAIL rst_mem_address got %h want 0", bus.mem_address); end
        checks++; if (bus.l1_response_data !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.l1_response_data); end
        checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL rst_hits got %0d want 0", hit_count); end
        checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL rst_misses got %0d want 0", miss_count); end
    endtask

    task automatic test_cold_read();
        logic [31:0] rd;
        int lat, f0, r0;
        fill_data = 32'hEEEEEEEE;
        f0 = fill_count;
        l1_access(1'b0, 32'h00000832, 32'h0, rd, lat);
        checks++; if (rd !== 32'hEEEEEEEE) begin errors++; $display("FAIL cold_rdata got %h want eeeeeeee", rd); end
        checks++; if (fill_count !== f0 + 1) begin errors++; $display("FAIL cold_fills got %0d want %0d", fill_count, f0 + 1); end
        checks++; if (fill_addr !== 32'h00000830) begin errors++; $display("FAIL cold_fill_addr got %h want 00000830", fill_addr); end
        checks++; if (wb_count !== 0) begin errors++; $display("FAIL cold_wb got %0d want 0", wb_count); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL cold_latency got %0d want 5", lat); end
        checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL cold_misses got %0d want 1", miss_count); end
        r0 = req_cycles;
        l1_access(1'b0, 32'h00000832, 32'h0, rd, lat);
        checks++; if (rd !== 32'hEEEEEEEE) begin errors++; $display("FAIL reread_rdata got %h want eeeeeeee", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL reread_latency got %0d want 2", lat); end
        checks++; if (req_cycles !== r0) begin errors++; $display("FAIL reread_mem_traffic got %0d want %0d", req_cycles, r0); end
        checks++; if (hit_count !== 32'd1) begin errors++; $display("FAIL reread_hits got %0d want 1", hit_count); end
    endtask

    task automatic test_lru();
        logic [31:0] rd;
        int lat, f0;
        fill_data = 32'h11111111; l1_access(1'b0, 32'hABCDE832, 32'h0, rd, lat);
        fill_data = 32'h22222222; l1_access(1'b0, 32'hAAAAA832, 32'h0, rd, lat);
        fill_data = 32'h33333333; l1_access(1'b0, 32'hFFFFF832, 32'h0, rd, lat);
        l1_access(1'b0, 32'h00000832, 32'h0, rd, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lru_touch_hit latency got %0d want 2", lat); end
        fill_data = 32'h44444444;
        l1_access(1'b0, 32'h12345832, 32'h0, rd, lat);
        checks++; if (rd !== 32'h44444444) begin errors++; $display("FAIL lru_new_rdata got %h want 44444444", rd); end
        l1_access(1'b0, 32'h00000832, 32'h0, rd, lat);
        checks++; if (lat !== 2 || rd !== 32'hEEEEEEEE) begin errors++; $display("FAIL lru_mru_kept lat=%0d rdata=%h want lat=2 rdata=eeeeeeee", lat, rd); end
        f0 = fill_count;
        fill_data = 32'hAB00AB00;
        l1_access(1'b0, 32'hABCDE832, 32'h0, rd, lat);
        checks++; if (fill_count !== f0 + 1) begin errors++; $display("FAIL lru_evicted_refill got %0d fills want %0d", fill_count, f0 + 1); end
        checks++; if (wb_count !== 0) begin errors++; $display("FAIL lru_clean_no_wb got %0d want 0", wb_count); end
        checks++; if (miss_count !== 32'd6 || hit_count !== 32'd3) begin errors++; $display("FAIL lru_counts got miss=%0d hit=%0d want miss=6 hit=3", miss_count, hit_count); end
    endtask

    task automatic test_writeback();
        logic [31:0] rd;
        int lat, r0, w0;
        r0 = req_cycles;
        l1_access(1'b1, 32'hABCDE832, 32'hBEEFDEAD, rd, lat);
        checks++; if (lat !== 2 || req_cycles !== r0) begin errors++; $display("FAIL wr_hit lat=%0d memcyc=%0d want lat=2 memcyc=%0d", lat, req_cycles, r0); end
        l1_access(1'b0, 32'h00000832, 32'h0, rd, lat);
        l1_access(1'b0, 32'h12345832, 32'h0, rd, lat);
        l1_access(1'b0, 32'hFFFFF832, 32'h0, rd, lat);
        checks++; if (hit_count !== 32'd7) begin errors++; $display("FAIL wb_prep_hits got %0d want 7", hit_count); end
        w0 = wb_count;
        fill_data = 32'h55550000;
        l1_access(1'b0, 32'h55555832, 32'h0, rd, lat);
        checks++; if (wb_count !== w0 + 1) begin errors++; $display("FAIL wb_count got %0d want %0d", wb_count, w0 + 1); end
        checks++; if (wb_addr !== 32'hABCDE830) begin errors++; $display("FAIL wb_addr got %h want abcde830", wb_addr); end
        checks++; if (wb_data !== 32'hBEEFDEAD) begin errors++; $display("FAIL wb_data got %h want beefdead", wb_data); end
        checks++; if (fill_seq !== wb_seq + 1) begin errors++; $display("FAIL wb_order fill_seq=%0d want %0d", fill_seq, wb_seq + 1); end
        checks++; if (fill_addr !== 32'h55555830 || rd !== 32'h55550000) begin errors++; $display("FAIL wb_fill addr=%h rdata=%h want 55555830 55550000", fill_addr, rd); end
        checks++; if (miss_count !== 32'd7) begin errors++; $display("FAIL wb_misses got %0d want 7", miss_count); end
    endtask

    task automatic test_write_miss();
        logic [31:0] rd;
        int lat, f0, w0, r0;
        f0 = fill_count;
        w0 = wb_count;
        fill_data = 32'hDEADDEAD;
        l1_access(1'b1, 32'h00001004, 32'h12345678, rd, lat);
        checks++; if (fill_count !== f0 + 1 || fill_addr !== 32'h00001004) begin errors++; $display("FAIL wmiss_fill got n=%0d addr=%h want n=%0d addr=00001004", fill_count, fill_addr, f0 + 1); end
        checks++; if (wb_count !== w0) begin errors++; $display("FAIL wmiss_no_wb got %0d want %0d", wb_count, w0); end
        checks++; if (miss_count !== 32'd8) begin errors++; $display("FAIL wmiss_misses got %0d want 8", miss_count); end
        r0 = req_cycles;
        l1_access(1'b0, 32'h00001004, 32'h0, rd, lat);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wmiss_readback got %h want 12345678", rd); end
        checks++; if (lat !== 2 || req_cycles !== r0) begin errors++; $display("FAIL wmiss_read_hit lat=%0d memcyc=%0d want lat=2 memcyc=%0d", lat, req_cycles, r0); end
    endtask

    task automatic test_back_to_back();
        bit got = 1'b0;
        int h0, r0;
        h0 = hit_count;
        r0 = req_cycles;
        @(posedge clk);
        #1;
        bus.l1_write_enable = 1'b0;
        bus.l1_address      = 32'h00001004;
        bus.l1_request      = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.l1_ready) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL b2b_first got no l1_ready want l1_ready within 20 cycles"); end
        @(posedge clk);
        #1;
        checks++; if (c_state !== 3'd0 || bus.l1_ready !== 1'b0) begin errors++; $display("FAIL b2b_idle state=%0d ready=%b want 0 0", c_state, bus.l1_ready); end
        @(posedge clk);
        #1;
        bus.l1_request = 1'b0;
        checks++; if (c_state !== 3'd1) begin errors++; $display("FAIL b2b_second_lookup state=%0d want 1", c_state); end
        @(posedge clk);
        #1;
        checks++; if (bus.l1_ready !== 1'b1 || bus.l1_response_data !== 32'h12345678) begin errors++; $display("FAIL b2b_second_resp ready=%b rdata=%h want 1 12345678", bus.l1_ready, bus.l1_response_data); end
        @(posedge clk);
        #1;
        checks++; if (c_state !== 3'd0 || hit_count !== h0 + 2 || req_cycles !== r0) begin errors++; $display("FAIL b2b_end state=%0d hits=%0d memcyc=%0d want 0 %0d %0d", c_state, hit_count, req_cycles, h0 + 2, r0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, f0, w0;
        bit got = 1'b0;
        l1_access(1'b1, 32'h00000832, 32'h0A0A0A0A, rd, lat);
        l1_access(1'b0, 32'h12345832, 32'h0, rd, lat);
        l1_access(1'b0, 32'h55555832, 32'h0, rd, lat);
        l1_access(1'b0, 32'hFFFFF832, 32'h0, rd, lat);
        @(posedge clk);
        #1;
        bus.l1_write_enable = 1'b0;
        bus.l1_address      = 32'h77777832;
        bus.l1_request      = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (c_state == 3'd2) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL rmid_reach_wb state=%0d want 2 within 20 cycles", c_state); end
        reset = 1'b1;
        bus.l1_request = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.mem_request !== 1'b0) begin errors++; $display("FAIL rmid_mem_request got %b want 0", bus.mem_request); end
        checks++; if (c_state !== 3'd0) begin errors++; $display("FAIL rmid_state got %0d want 0", c_state); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rmid_counters hit=%0d miss=%0d want 0 0", hit_count, miss_count); end
        reset = 1'b0;
        f0 = fill_count;
        w0 = wb_count;
        fill_data = 32'h0C0C0C0C;
        l1_access(1'b0, 32'h00000832, 32'h0, rd, lat);
        l1_access(1'b0, 32'h77777832, 32'h0, rd, lat);
        l1_access(1'b0, 32'h00001004, 32'h0, rd, lat);
        checks++; if (fill_count !== f0 + 3) begin errors++; $display("FAIL rmid_all_invalid fills=%0d want %0d", fill_count, f0 + 3); end
        checks++; if (wb_count !== w0) begin errors++; $display("FAIL rmid_no_wb got %0d want %0d", wb_count, w0); end
        checks++; if (miss_count !== 32'd3 || hit_count !== 32'd0) begin errors++; $display("FAIL rmid_counts miss=%0d hit=%0d want 3 0", miss_count, hit_count); end
        checks++; if (rd !== 32'h0C0C0C0C) begin errors++; $display("FAIL rmid_rdata got %h want 0c0c0c0c", rd); end
    endtask

    initial begin
        reset               = 1'b1;
        bus.l1_request      = 1'b0;
        bus.l1_write_enable = 1'b0;
        bus.l1_address      = 32'h0;
        bus.l1_write_data   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_cold_read();
        test_lru();
        test_writeback();
        test_write_miss();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
